// File: rtl/maj_netlist_sequencer_pkg.sv
// maj_seq_pkg: shared sizes, state encoding and gate record for the MAJ3 netlist sequencer
package maj_seq_pkg;
  localparam int NUM_IN    = 7;
  localparam int MAX_GATES = 16;
  localparam int SEL_W     = 5;
  localparam int GIDX_W    = 4;
  localparam int TT_W      = 2 ** NUM_IN;
  localparam int XI_W      = $clog2(NUM_IN + 1);
  localparam logic [SEL_W-1:0] SEL_CONST0 = '0;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;
  typedef struct packed {
    logic             inv_c;
    logic [SEL_W-1:0] sel_c;
    logic             inv_b;
    logic [SEL_W-1:0] sel_b;
    logic             inv_a;
    logic [SEL_W-1:0] sel_a;
  } gate_t;
  function automatic int sel_base_gate();
    return NUM_IN + 1;
  endfunction
endpackage

// File: rtl/maj_netlist_sequencer_if.sv
// maj_netlist_sequencer_if: program-RAM write port, sweep control and truth-table result
interface maj_netlist_sequencer_if;
  import maj_seq_pkg::*;
  logic                       cfg_we;
  logic [GIDX_W-1:0]          cfg_addr;
  logic [3*(SEL_W+1)-1:0]     cfg_data;
  logic [GIDX_W:0]            num_gates;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [TT_W-1:0]            tt_out;
  modport master (
    output cfg_we, cfg_addr, cfg_data, num_gates, start,
    input  busy, done, err, tt_out
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, num_gates, start,
    output busy, done, err, tt_out
  );
endinterface

// File: rtl/maj_netlist_sequencer_maj3_unit.sv
// maj3_unit: the single shared evaluator, majority of three optionally inverted operands
module maj3_unit (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] inv_i,
  output logic       y_o
);
  logic a, b, c;
  assign a   = a_i ^ inv_i[0];
  assign b   = b_i ^ inv_i[1];
  assign c   = c_i ^ inv_i[2];
  assign y_o = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/maj_netlist_sequencer.sv
// maj_netlist_sequencer: walks every gate of a stored MAJ3 netlist over every minterm to build its truth table
module maj_netlist_sequencer
  import maj_seq_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  maj_netlist_sequencer_if.slave bus_if
);
  state_e                    state_q, state_d;
  logic [NUM_IN:0]           m_q, m_d;
  logic [GIDX_W-1:0]         g_q, g_d;
  logic [GIDX_W:0]           gn_q, gn_d;
  logic                      err_q, err_d;
  logic [TT_W-1:0]           tt_q, tt_d;
  logic [MAX_GATES-1:0]      gval_q, gval_d;
  gate_t                     ram_q [MAX_GATES];
  gate_t                     gate;
  logic [2:0][SEL_W-1:0]     sel;
  logic [2:0]                inv, opv, ope;
  logic                      y, start_ok, last_g, last_m;
  assign gate     = ram_q[g_q];
  assign sel      = {gate.sel_c, gate.sel_b, gate.sel_a};
  assign inv      = {gate.inv_c, gate.inv_b, gate.inv_a};
  assign start_ok = bus_if.num_gates != '0 && bus_if.num_gates <= (GIDX_W+1)'(MAX_GATES);
  assign last_g   = (GIDX_W+1)'(g_q) + 1'b1 == gn_q;
  assign last_m   = m_q == (NUM_IN+1)'(TT_W - 1);
  for (genvar i = 0; i < 3; i++) begin : g_op
    logic [SEL_W-1:0] gk;
    logic [XI_W-1:0]  xi;
    logic             is_x, is_g;
    assign xi      = XI_W'(sel[i] - SEL_W'(1));
    assign gk      = sel[i] - SEL_W'(sel_base_gate());
    assign is_x    = sel[i] != SEL_CONST0 && sel[i] <= SEL_W'(NUM_IN);
    assign is_g    = sel[i] >= SEL_W'(sel_base_gate()) && gk < SEL_W'(g_q);
    assign opv[i]  = is_x ? m_q[xi] : is_g & gval_q[gk[GIDX_W-1:0]];
    assign ope[i]  = sel[i] != SEL_CONST0 && !is_x && !is_g;
  end
  maj3_unit u_maj (
    .a_i  (opv[0]),
    .b_i  (opv[1]),
    .c_i  (opv[2]),
    .inv_i(inv),
    .y_o  (y)
  );
  assign bus_if.busy   = state_q == EVAL;
  assign bus_if.done   = state_q == DONE;
  assign bus_if.err    = err_q;
  assign bus_if.tt_out = tt_q;
  // Next state: accept a start, step g then m through the sweep, capture gate values and truth-table bits
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    gn_d    = gn_q;
    err_d   = err_q;
    tt_d    = tt_q;
    gval_d  = gval_q;
    case (state_q)
      IDLE: begin
        if (bus_if.start && start_ok) begin
          state_d = EVAL;
          m_d     = '0;
          g_d     = '0;
          gn_d    = bus_if.num_gates;
          err_d   = 1'b0;
          tt_d    = '0;
        end else if (bus_if.start) begin
          err_d = 1'b1;
        end
      end
      EVAL: begin
        gval_d[g_q] = y;
        err_d       = err_q | (|ope);
        if (last_g) begin
          tt_d[m_q[NUM_IN-1:0]] = y;
          g_d     = '0;
          state_d = last_m ? DONE : EVAL;
          m_d     = last_m ? m_q : m_q + 1'b1;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus_if.cfg_we && state_q == EVAL) err_d = 1'b1;
  end
  // Sweep state and results; the program RAM survives reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      g_q     <= '0;
      gn_q    <= '0;
      err_q   <= 1'b0;
      tt_q    <= '0;
      gval_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      g_q     <= g_d;
      gn_q    <= gn_d;
      err_q   <= err_d;
      tt_q    <= tt_d;
      gval_q  <= gval_d;
    end
  end
  // Program RAM takes writes only while no sweep is reading it
  always_ff @(posedge clk) begin
    if (bus_if.cfg_we && state_q != EVAL) ram_q[bus_if.cfg_addr] <= gate_t'(bus_if.cfg_data);
  end
endmodule

// File: tb/tb_maj_netlist_sequencer.sv
// tb_maj_netlist_sequencer: directed and random sweeps checked against a minterm-by-minterm netlist model
module tb_maj_netlist_sequencer;
  import maj_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   psel [MAX_GATES][3];
  bit   pinv [MAX_GATES][3];
  logic [TT_W-1:0] want3;
  always #5 clk = ~clk;
  maj_netlist_sequencer_if bus();
  maj_netlist_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus.slave)
  );
  task automatic check(input string tag, input logic [TT_W-1:0] obs, input logic [TT_W-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  function automatic logic [TT_W-1:0] model(input int gn, output bit e);
    bit v [MAX_GATES];
    int s, cnt;
    bit o;
    model = '0;
    e = 1'b0;
    for (int m = 0; m < TT_W; m++) begin
      for (int g = 0; g < gn; g++) begin
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
          s = psel[g][i];
          o = 1'b0;
          if (s >= 1 && s <= NUM_IN) o = bit'((m >> (s - 1)) & 1);
          else if (s > NUM_IN && s - NUM_IN - 1 < g) o = v[s - NUM_IN - 1];
          else if (s != 0) e = 1'b1;
          cnt += int'(o ^ pinv[g][i]);
        end
        v[g] = cnt >= 2;
      end
      model[m] = v[gn - 1];
    end
  endfunction
  task automatic prog(input int k, input int sa, input int ia, input int sb, input int ib, input int sc, input int ic);
    psel[k][0] = sa; psel[k][1] = sb; psel[k][2] = sc;
    pinv[k][0] = bit'(ia); pinv[k][1] = bit'(ib); pinv[k][2] = bit'(ic);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = GIDX_W'(k);
    bus.cfg_data = {1'(ic), SEL_W'(sc), 1'(ib), SEL_W'(sb), 1'(ia), SEL_W'(sa)};
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask
  task automatic sweep(input int gn, input int poke, output int lat);
    @(negedge clk);
    bus.num_gates = (GIDX_W+1)'(gn);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy after start", bus.busy, 1'b1);
    lat = -1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (bus.done) begin
        lat = cyc;
        break;
      end
      bus.cfg_we = cyc == poke;
      if (cyc == poke) begin
        bus.cfg_addr = '0;
        bus.cfg_data = '1;
      end
      @(negedge clk);
    end
    bus.cfg_we = 1'b0;
  endtask
  task automatic run(input string tag, input int gn, input int poke);
    int lat;
    bit e;
    logic [TT_W-1:0] want;
    want = model(gn, e);
    if (poke > 0) e = 1'b1;
    sweep(gn, poke, lat);
    check({tag, " latency"}, TT_W'(lat), TT_W'(TT_W * gn + 1));
    check({tag, " tt"}, bus.tt_out, want);
    check({tag, " err"}, bus.err, e);
    check({tag, " busy at done"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, " done pulse"}, {bus.done, bus.busy}, 2'b00);
  endtask
  initial begin
    int gn, s;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.num_gates = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy/done/err", {bus.busy, bus.done, bus.err}, 3'b000);
    check("reset tt", bus.tt_out, '0);
    rst = 1'b0;
    prog(0, 1, 0, 2, 0, 3, 0);
    run("s1 maj", 1, 0);
    check("s1 const", bus.tt_out, {16{8'hE8}});
    prog(0, 1, 0, 2, 0, 0, 0);
    run("s2 and", 1, 0);
    check("s2 and const", bus.tt_out, {16{8'h88}});
    prog(0, 1, 0, 2, 0, 0, 1);
    run("s2 or", 1, 0);
    check("s2 or const", bus.tt_out, {16{8'hEE}});
    prog(0, 1, 0, 2, 0, 3, 0);
    prog(1, 8, 1, 4, 0, 0, 0);
    run("s3 two gates", 2, 0);
    for (int m = 0; m < TT_W; m++) want3[m] = !(((m & 1) + ((m >> 1) & 1) + ((m >> 2) & 1)) >= 2) && m[3];
    check("s3 const", bus.tt_out, want3);
    prog(0, 8, 0, 2, 0, 3, 0);
    run("s4 selfref", 1, 0);
    check("s4 err set", bus.err, 1'b1);
    prog(0, 1, 0, 2, 0, 3, 0);
    run("s4 recover", 1, 0);
    check("s4 err cleared", bus.err, 1'b0);
    @(negedge clk);
    bus.num_gates = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("s5 g0 busy", bus.busy, 1'b0);
    check("s5 g0 err", bus.err, 1'b1);
    bus.num_gates = (GIDX_W+1)'(MAX_GATES + 1); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("s5 g17 busy/err", {bus.busy, bus.err}, 2'b01);
    run("s5 write while busy", 1, 5);
    run("s5 ram unchanged", 1, 0);
    check("s5 const", bus.tt_out, {16{8'hE8}});
    @(negedge clk);
    bus.num_gates = 1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    check("s6 tt before rst nonzero", {127'd0, bus.tt_out != '0}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6 rst busy/done", {bus.busy, bus.done}, 2'b00);
    check("s6 rst tt", bus.tt_out, '0);
    repeat (3) @(negedge clk);
    check("s6 no done after rst", bus.done, 1'b0);
    run("s6 restart", 1, 0);
    repeat (5) @(negedge clk);
    check("s6 tt held", bus.tt_out, {16{8'hE8}});
    for (int r = 0; r < 6; r++) begin
      gn = $urandom_range(1, MAX_GATES);
      for (int k = 0; k < gn; k++) begin
        int sv [3];
        for (int i = 0; i < 3; i++) begin
          s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NUM_IN + k);
          sv[i] = s;
        end
        prog(k, sv[0], $urandom_range(0, 1), sv[1], $urandom_range(0, 1), sv[2], $urandom_range(0, 1));
      end
      run($sformatf("rand%0d g%0d", r, gn), gn, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
